// File: rtl/common_types_pkg.sv
// Shared types for the execute stage: multiplier FSM states, iteration count
// and the double-word type that holds a full 32x32 product.
package common_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_ITERS = 32;

    typedef logic [63:0] dword_t;

endpackage

// File: rtl/execute_multiplier.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional MULT_EARLY_OUT_EN ends CALC once the remaining multiplier bits are zero.
module execute_multiplier
    import common_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             flush,
    input  logic             mult_half,
    input  logic             signed_a,
    input  logic             signed_b,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(MULT_ITERS) + 1;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic n);
        return n ? (~p + PW'(1)) : p;
    endfunction

    mult_state_t      state_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             half_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]    acc_d;
    logic [WIDTH-1:0] mplier_d;
    logic [PW-1:0]    product;
    logic [WIDTH-1:0] prod_sel;
    logic             last_iter;

    assign mag_a    = magnitude(op_a, signed_a);
    assign mag_b    = magnitude(op_b, signed_b);
    assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mplier_d = mplier_q >> 1;
    // Product is formed from the final accumulation so result is ready on entry to DONE.
    assign product  = apply_sign(acc_d, neg_q);
    assign prod_sel = half_q ? product[PW-1:WIDTH] : product[WIDTH-1:0];

`ifdef MULT_EARLY_OUT_EN
    assign last_iter = (mplier_d == '0) || (cnt_q == CW'(1));
`else
    assign last_iter = (cnt_q == CW'(1));
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            half_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                            mplier_q <= mag_b;
                            neg_q    <= (signed_a & op_a[WIDTH-1]) ^ (signed_b & op_b[WIDTH-1]);
                            half_q   <= mult_half;
                            acc_q    <= '0;
                            cnt_q    <= CW'(MULT_ITERS);
`ifdef MULT_EARLY_OUT_EN
                            if (mag_b == '0) begin
                                state_q  <= DONE;
                                done_q   <= 1'b1;
                                result_q <= '0;
                            end else begin
                                state_q <= CALC;
                            end
`else
                            state_q <= CALC;
`endif
                        end
                    end
                    CALC: begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_d;
                        cnt_q    <= cnt_q - CW'(1);
                        if (last_iter) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= prod_sel;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Low in the DONE cycle so the decode latch advances on that edge.
    assign stall  = start & ~done_q & ~flush;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_execute_multiplier.sv
// Directed bench for execute_multiplier: per-cycle compare against a 64-bit
// arithmetic model, plus literal expectations for the key products and latencies.
module tb_execute_multiplier;

    logic        clk = 1'b0;
    logic        nrst, start, flush, mult_half, signed_a, signed_b;
    logic [31:0] op_a, op_b;
    logic        stall, done;
    logic [31:0] result;

    execute_multiplier #(.WIDTH(32)) dut (
        .clk(clk), .nrst(nrst), .start(start), .flush(flush),
        .mult_half(mult_half), .signed_a(signed_a), .signed_b(signed_b),
        .op_a(op_a), .op_b(op_b), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    bit          m_active = 1'b0;
    int          m_cyc, m_lat, done_cyc;
    logic [31:0] m_exp, last_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                              input logic sa, input logic sb, input logic h);
        logic [63:0] xa, xb, p;
        xa = sa ? {{32{a[31]}}, a} : {32'b0, a};
        xb = sb ? {{32{b[31]}}, b} : {32'b0, b};
        p  = xa * xb;
        return h ? p[63:32] : p[31:0];
    endfunction

    function automatic int model_lat(input logic [31:0] b, input logic sb);
`ifdef MULT_EARLY_OUT_EN
        logic [31:0] bm;
        int msb;
        bm  = (sb && b[31]) ? (32'd0 - b) : b;
        msb = -1;
        for (int i = 0; i < 32; i++) if (bm[i]) msb = i;
        return (msb < 0) ? 1 : msb + 2;
`else
        return 33 + 0 * int'(b[0] & sb);
`endif
    endfunction

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (m_active) begin
            chk("done_timing", 64'(done), 64'(m_cyc == m_lat));
            chk("stall_busy", 64'(stall), 64'(start && !flush && m_cyc != m_lat));
            if (done) begin
                chk("result", 64'(result), 64'(m_exp));
                last_res = result;
                done_cyc = m_cyc;
                m_active = 1'b0;
            end else begin
                m_cyc++;
            end
        end else begin
            chk("done_idle", 64'(done), 64'd0);
            chk("stall_idle", 64'(stall), 64'(start & ~flush));
        end
    end

    task automatic begin_op(input logic [31:0] a, input logic [31:0] b,
                            input logic sa, input logic sb, input logic h);
        op_a = a; op_b = b; signed_a = sa; signed_b = sb; mult_half = h;
        start = 1'b1; flush = 1'b0;
        m_exp = model_res(a, b, sa, sb, h);
        m_lat = model_lat(b, sb);
        m_cyc = 0;
        m_active = 1'b1;
    endtask

    task automatic mul(input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb, input logic h, input bit scramble);
        begin_op(a, b, sa, sb, h);
        for (int i = 0; i < 60 && m_active; i++) begin
            @(posedge clk); #1;
            if (scramble) begin op_a = $urandom; op_b = $urandom; end
        end
        if (m_active) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: no done after 60 cycles, expected at cycle %0d", m_lat);
            m_active = 1'b0;
        end
    endtask

    task automatic idle();
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0; start = 1'b1; flush = 1'b0; mult_half = 1'b0;
        signed_a = 1'b0; signed_b = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_stall", 64'(stall), 64'd1);
        start = 1'b0; nrst = 1'b1;
        @(posedge clk); #1;

        mul(32'd7, 32'd6, 0, 0, 0, 0);
        chk("lit_7x6", 64'(last_res), 64'd42);
`ifdef MULT_EARLY_OUT_EN
        chk("lit_7x6_lat", 64'(done_cyc), 64'd4);
`else
        chk("lit_7x6_lat", 64'(done_cyc), 64'd33);
`endif
        idle();

        // Back-to-back: start stays high across the DONE cycle.
        mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 1, 0);
        chk("lit_mulh_m1", 64'(last_res), 64'h0);
        mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0, 0);
        chk("lit_mul_m1", 64'(last_res), 64'h1);
        mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 0);
        chk("lit_mulhu", 64'(last_res), 64'hFFFFFFFE);
        mul(32'hFFFFFFFF, 32'd2, 1, 0, 1, 0);
        chk("lit_mulhsu", 64'(last_res), 64'hFFFFFFFF);
        mul(32'h80000000, 32'h80000000, 1, 1, 1, 0);
        chk("lit_min_hi", 64'(last_res), 64'h40000000);
        mul(32'h80000000, 32'h80000000, 1, 1, 0, 0);
        chk("lit_min_lo", 64'(last_res), 64'h0);
        idle();

        mul(32'hFFFFFFFD, 32'd5, 1, 1, 0, 0);
        chk("lit_neg15", 64'(last_res), 64'hFFFFFFF1);
        idle();
        mul(32'd5, 32'd0, 0, 0, 0, 0);
        chk("lit_b0", 64'(last_res), 64'h0);
        idle();
        mul(32'd9, 32'd1, 0, 0, 0, 0);
        chk("lit_9x1", 64'(last_res), 64'd9);
`ifdef MULT_EARLY_OUT_EN
        chk("lit_9x1_lat", 64'(done_cyc), 64'd2);
`else
        chk("lit_9x1_lat", 64'(done_cyc), 64'd33);
`endif
        idle();

        // Operands wiggle during CALC; only the IDLE sample counts.
        mul(32'h12345678, 32'h9ABCDEF0, 0, 0, 1, 1);
        idle();

        // Flush at cycle 10, IDLE at 11, new start at 12 completes at 45.
        begin_op(32'd7, 32'h80000000, 0, 0, 0);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1; m_active = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        mul(32'd3, 32'h80000001, 0, 0, 0, 0);
        chk("lit_after_flush", 64'(last_res), 64'h80000003);
        chk("lit_after_flush_lat", 64'(done_cyc + 12), 64'd45);
        idle();

        // Reset mid-operation clears done/result at once.
        begin_op(32'd5, 32'h80000000, 0, 0, 0);
        repeat (5) begin @(posedge clk); #1; end
        m_active = 1'b0; start = 1'b0; nrst = 1'b0;
        #1;
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        mul(32'd9, 32'd1, 0, 0, 0, 0);
        chk("lit_after_reset", 64'(last_res), 64'd9);
        idle();
        repeat (3) begin @(posedge clk); #1; end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
